// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// ALU operations and datapath mux selects.
package riscv_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_EXEC    = 4'd2;
    localparam state_t S_ALUWB   = 4'd3;
    localparam state_t S_MEMADDR = 4'd4;
    localparam state_t S_MEMRD   = 4'd5;
    localparam state_t S_MEMWB   = 4'd6;
    localparam state_t S_MEMWR   = 4'd7;
    localparam state_t S_BRANCH  = 4'd8;
    localparam state_t S_JUMP    = 4'd9;
    localparam state_t S_TRAP    = 4'd10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_REG   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;
    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;
    localparam logic [1:0] RES_PC     = 2'd3;

    function automatic logic opcode_known(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// ALU-decode request/response bundle between the controller FSM (master)
// and the combinational ALU decoder (slave).
interface riscv_multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       exec;
    logic [3:0] alu_ctrl;

    modport master (output opcode, funct3, funct7_b5, exec, input alu_ctrl);
    modport slave  (input opcode, funct3, funct7_b5, exec, output alu_ctrl);
endinterface

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU operation decode; only EXEC of an R/I instruction selects
// anything other than ADD.
module riscv_alu_decoder
    import riscv_pkg::*;
(
    riscv_multicycle_ctrl_if.slave dec
);
    logic is_r;

    assign is_r = (dec.opcode == OP_R);

    always_comb begin
        dec.alu_ctrl = ALU_ADD;
        if (dec.exec && (is_r || dec.opcode == OP_I)) begin
            case (dec.funct3)
                3'b000:  dec.alu_ctrl = (is_r && dec.funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b001:  dec.alu_ctrl = ALU_SLL;
                3'b010:  dec.alu_ctrl = ALU_SLT;
                3'b011:  dec.alu_ctrl = ALU_SLTU;
                3'b100:  dec.alu_ctrl = ALU_XOR;
                // funct7[5] picks arithmetic shift for both SRA and SRAI
                3'b101:  dec.alu_ctrl = dec.funct7_b5 ? ALU_SRA : ALU_SRL;
                3'b110:  dec.alu_ctrl = ALU_OR;
                default: dec.alu_ctrl = ALU_AND;
            endcase
        end
    end
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM with retire counter and memory watchdog.
// Define RISCV_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes instead of retiring them as NOPs.
module riscv_multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int p_TimeoutCycles = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [31:0] i_Inst,
    input  logic        i_IMemReady,
    input  logic        i_DMemReady,
    input  logic        i_BranchTaken,
    output logic        o_IMemReq,
    output logic        o_DMemRead,
    output logic        o_DMemWrite,
    output logic        o_PCWrite,
    output logic        o_OldPCWrite,
    output logic        o_IRWrite,
    output logic        o_RegWrite,
    output logic [1:0]  o_ALUSrcA,
    output logic [1:0]  o_ALUSrcB,
    output logic [1:0]  o_ResultSrc,
    output logic [3:0]  o_ALUCtrl,
    output logic [3:0]  o_State,
    output logic [31:0] o_InstRetired,
    output logic        o_MemTimeout,
    output logic        o_Illegal
);
    localparam int CW = $clog2(p_TimeoutCycles + 2);

    state_t        state, state_nxt;
    logic          restart;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   retired;
    logic          timeout_flag;
    logic          waiting, ready, expired, retire, rd_nz;
    logic [6:0]    opcode;
    logic          unused_inst;

    assign opcode      = i_Inst[6:0];
    assign rd_nz       = |i_Inst[11:7];
    assign unused_inst = ^{i_Inst[31], i_Inst[29:15]};

    riscv_multicycle_ctrl_if dec_if ();
    assign dec_if.opcode    = opcode;
    assign dec_if.funct3    = i_Inst[14:12];
    assign dec_if.funct7_b5 = i_Inst[30];
    assign dec_if.exec      = (state == S_EXEC);
    riscv_alu_decoder u_alu_dec (.dec(dec_if));
    assign o_ALUCtrl = dec_if.alu_ctrl;

    // restart marks an idle FETCH cycle after reset or a timeout so no request is pending
    assign waiting = !restart && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
    assign ready   = (state == S_FETCH) ? i_IMemReady : i_DMemReady;
    assign expired = waiting && !ready && (wait_cnt == CW'(p_TimeoutCycles));

    always_comb begin
        state_nxt    = state;
        retire       = 1'b0;
        o_IMemReq    = 1'b0;
        o_DMemRead   = 1'b0;
        o_DMemWrite  = 1'b0;
        o_PCWrite    = 1'b0;
        o_OldPCWrite = 1'b0;
        o_IRWrite    = 1'b0;
        o_RegWrite   = 1'b0;
        o_ALUSrcA    = SRCA_PC;
        o_ALUSrcB    = SRCB_REG;
        o_ResultSrc  = RES_ALUOUT;
        case (state)
            S_FETCH: if (!restart) begin
                o_IMemReq   = 1'b1;
                o_ALUSrcB   = SRCB_FOUR;
                o_ResultSrc = RES_ALU;
                if (i_IMemReady) begin
                    o_IRWrite    = 1'b1;
                    o_OldPCWrite = 1'b1;
                    o_PCWrite    = 1'b1;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                // old PC + imm lands in ALUOut as the branch/JAL target
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_R, OP_I, OP_LUI, OP_AUIPC: state_nxt = S_EXEC;
                    OP_LOAD, OP_STORE:            state_nxt = S_MEMADDR;
                    OP_BRANCH:                    state_nxt = S_BRANCH;
                    OP_JAL, OP_JALR:              state_nxt = S_JUMP;
                    default: begin
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
                        state_nxt = S_TRAP;
`else
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
`endif
                    end
                endcase
            end
            S_EXEC: begin
                o_ALUSrcA = (opcode == OP_AUIPC) ? SRCA_OLDPC :
                            (opcode == OP_LUI)   ? SRCA_ZERO  : SRCA_REG;
                o_ALUSrcB = (opcode == OP_R) ? SRCB_REG : SRCB_IMM;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                o_RegWrite = rd_nz;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMADDR: begin
                o_ALUSrcA = SRCA_REG;
                o_ALUSrcB = SRCB_IMM;
                state_nxt = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                o_DMemRead = 1'b1;
                if (i_DMemReady) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                o_ResultSrc = RES_MEM;
                o_RegWrite  = rd_nz;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_MEMWR: begin
                o_DMemWrite = 1'b1;
                if (i_DMemReady) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_BRANCH: begin
                o_ALUSrcA = SRCA_REG;
                o_ALUSrcB = SRCB_REG;
                o_PCWrite = i_BranchTaken;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                // JALR recomputes rs1+imm; the datapath clears bit 0 of the target
                o_ALUSrcA   = (opcode == OP_JALR) ? SRCA_REG : SRCA_OLDPC;
                o_ALUSrcB   = SRCB_IMM;
                o_ResultSrc = RES_PC;
                o_RegWrite  = rd_nz;
                o_PCWrite   = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_FETCH;
        endcase
        if (expired) state_nxt = S_FETCH;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state        <= S_FETCH;
            restart      <= 1'b1;
            wait_cnt     <= '0;
            retired      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            restart  <= expired;
            wait_cnt <= (waiting && !ready && !expired) ? wait_cnt + 1'b1 : '0;
            if (retire)  retired      <= retired + 32'd1;
            if (expired) timeout_flag <= 1'b1;
        end
    end

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    logic illegal_flag;
    always_ff @(posedge i_Clk) begin
        if (i_Rst)                                           illegal_flag <= 1'b0;
        else if (state == S_DECODE && !opcode_known(opcode)) illegal_flag <= 1'b1;
    end
    assign o_Illegal = illegal_flag;
`else
    assign o_Illegal = 1'b0;
`endif

    assign o_State       = state;
    assign o_InstRetired = retired;
    assign o_MemTimeout  = timeout_flag;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized instruction stream with memory latency injection, checked against a
// per-instruction cost/effect model; plus watchdog, reset and illegal-opcode cases.
module tb_riscv_multicycle_ctrl;
    import riscv_pkg::*;

    localparam int TO = 16;
    localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_JMP = 4, C_BAD = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0;
    logic        imem_rdy = 1'b0, dmem_rdy = 1'b0, taken = 1'b0;
    logic        imem_req, dmem_rd, dmem_wr, pc_wr, oldpc_wr, ir_wr, reg_wr;
    logic [1:0]  src_a, src_b, res_src;
    logic [3:0]  alu_ctrl, state;
    logic [31:0] retired;
    logic        mem_to, illegal;

    int n_chk = 0, n_fail = 0;
    logic [31:0] exp_ret = '0;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(.p_TimeoutCycles(TO)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Inst(inst),
        .i_IMemReady(imem_rdy), .i_DMemReady(dmem_rdy), .i_BranchTaken(taken),
        .o_IMemReq(imem_req), .o_DMemRead(dmem_rd), .o_DMemWrite(dmem_wr),
        .o_PCWrite(pc_wr), .o_OldPCWrite(oldpc_wr), .o_IRWrite(ir_wr), .o_RegWrite(reg_wr),
        .o_ALUSrcA(src_a), .o_ALUSrcB(src_b), .o_ResultSrc(res_src), .o_ALUCtrl(alu_ctrl),
        .o_State(state), .o_InstRetired(retired), .o_MemTimeout(mem_to), .o_Illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'h33, 7'h13, 7'h37, 7'h17: return C_ALU;
            7'h03:                      return C_LOAD;
            7'h23:                      return C_STORE;
            7'h63:                      return C_BR;
            7'h6F, 7'h67:               return C_JMP;
            default:                    return C_BAD;
        endcase
    endfunction

    // RV32I mnemonic table: R uses funct7[5] for SUB/SRA, I only for SRAI
    function automatic logic [3:0] alu_ref(input logic [31:0] w);
        logic [3:0] tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (w[6:0] != 7'h33 && w[6:0] != 7'h13) return ALU_ADD;
        if (w[14:12] == 3'd0 && w[6:0] == 7'h33 && w[30]) return ALU_SUB;
        if (w[14:12] == 3'd5 && w[30]) return ALU_SRA;
        return tbl[w[14:12]];
    endfunction

    function automatic int exp_cycles(input int c, input int di, input int dd);
        case (c)
            C_ALU:       return di + 4;
            C_LOAD:      return di + dd + 5;
            C_STORE:     return di + dd + 4;
            C_BR, C_JMP: return di + 3;
            default:     return di + 2;
        endcase
    endfunction

    task automatic run_inst(input logic [31:0] w, input int di, input int dd, input bit tk,
                            output bit done, output int cyc, output int regw, output int pcw,
                            output int drd, output int dwr, output int nonadd,
                            output logic [3:0] exec_op);
        int icnt, dcnt;
        bit started;
        logic [31:0] r0;
        icnt = 0; dcnt = 0; started = 0; done = 0; cyc = 0; regw = 0; pcw = 0;
        drd = 0; dwr = 0; nonadd = 0; exec_op = 4'hF;
        r0 = retired;
        inst = w; taken = tk;
        for (int k = 0; k < 80; k++) begin
            imem_rdy = imem_req && (icnt == di);
            dmem_rdy = (dmem_rd || dmem_wr) && (dcnt == dd);
            #1;
            if (imem_req) begin started = 1; icnt++; end
            if (dmem_rd || dmem_wr) dcnt++;
            if (started) begin
                cyc++;
                regw += int'(reg_wr); pcw += int'(pc_wr);
                drd += int'(dmem_rd); dwr += int'(dmem_wr);
                if (state == S_EXEC) exec_op = alu_ctrl;
                else if (alu_ctrl != ALU_ADD) nonadd++;
            end
            @(posedge clk); #1;
            if (retired != r0) begin done = 1; break; end
        end
        imem_rdy = 1'b0; dmem_rdy = 1'b0;
    endtask

    task automatic do_inst(input logic [31:0] w, input int di, input int dd, input bit tk,
                           input logic exp_to);
        bit done;
        int cyc, regw, pcw, drd, dwr, nonadd, c;
        logic [3:0] xop;
        c = cls_of(w[6:0]);
        run_inst(w, di, dd, tk, done, cyc, regw, pcw, drd, dwr, nonadd, xop);
        exp_ret = exp_ret + 32'd1;
        chk("retire_seen", done, 1);
        chk("retired_cnt", retired, exp_ret);
        chk("cycles", cyc, exp_cycles(c, di, dd));
        chk("regwrite", regw, ((c == C_ALU || c == C_LOAD || c == C_JMP) && w[11:7] != 0) ? 1 : 0);
        chk("pcwrite", pcw, 1 + ((c == C_BR && tk) ? 1 : 0) + ((c == C_JMP) ? 1 : 0));
        chk("dmem_read", drd, (c == C_LOAD) ? dd + 1 : 0);
        chk("dmem_write", dwr, (c == C_STORE) ? dd + 1 : 0);
        chk("alu_not_add", nonadd, 0);
        if (c == C_ALU) chk("alu_exec", xop, alu_ref(w));
        chk("timeout_flag", mem_to, exp_to);
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_rdy = 1'b0; dmem_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_ret = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [9];
        logic [31:0] w;
        int req_cyc, rd_seen, di, dd;
        bit done;
        int cyc, regw, pcw, drd, dwr, nonadd;
        logic [3:0] xop;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

        do_reset();
        #1;
        chk("rst_state", state, S_FETCH);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_retired", retired, 0);
        chk("rst_timeout", mem_to, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_selects", {src_a, src_b, res_src, pc_wr, reg_wr}, 0);
        @(posedge clk); #1;

        do_inst(32'h002081B3, 0, 0, 0, 1'b0);   // ADD x3,x1,x2
        do_inst(32'h0000A283, 0, 3, 0, 1'b0);   // LW x5,0(x1), data 3 cycles late
        do_inst(32'h00208463, 0, 0, 0, 1'b0);   // BEQ not taken
        do_inst(32'h00208463, 0, 0, 1, 1'b0);   // BEQ taken
        do_inst(32'h0000A023, 0, 0, 0, 1'b0);   // SW
        do_inst(32'h0000006F, 0, 0, 0, 1'b0);   // JAL x0: no register write

        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 4) == 0) w[11:7] = 5'd0;
            di = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            if (i % 10 == 5) di = TO;
            if (i % 10 == 7) dd = TO;
            do_inst(w, di, dd, 1'($urandom_range(0, 1)), 1'b0);
        end

        // instruction memory silent: request held TO+1 cycles, then dropped
        inst = 32'h002081B3; req_cyc = 0;
        for (int k = 0; k < 60; k++) begin
            if (imem_req) req_cyc++;
            else if (req_cyc > 0) break;
            @(posedge clk); #1;
        end
        chk("to_req_cycles", req_cyc, TO + 1);
        chk("to_req_dropped", imem_req, 0);
        chk("to_flag", mem_to, 1);
        chk("to_state", state, S_FETCH);
        chk("to_no_retire", retired, exp_ret);
        do_inst(32'h002081B3, 1, 0, 0, 1'b1);

        // reset in the middle of a load wait
        inst = 32'h0000A283; rd_seen = 0;
        for (int k = 0; k < 30; k++) begin
            imem_rdy = imem_req; dmem_rdy = 1'b0;
            #1;
            if (dmem_rd) rd_seen++;
            if (rd_seen == 3) break;
            @(posedge clk); #1;
        end
        chk("memrd_reached", rd_seen, 3);
        rst = 1'b1; imem_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; exp_ret = '0;
        chk("mrst_state", state, S_FETCH);
        chk("mrst_dmem_read", dmem_rd, 0);
        chk("mrst_retired", retired, 0);
        chk("mrst_timeout", mem_to, 0);
        chk("mrst_imem_req", imem_req, 0);
        @(posedge clk); #1;
        do_inst(32'h00500093, 0, 0, 0, 1'b0);  // ADDI x1,x0,5

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        run_inst(32'h0000007F, 0, 0, 0, done, cyc, regw, pcw, drd, dwr, nonadd, xop);
        chk("trap_no_retire", done, 0);
        chk("trap_state", state, S_TRAP);
        chk("trap_illegal", illegal, 1);
        chk("trap_retired", retired, exp_ret);
        do_reset();
        #1;
        chk("trap_rst_illegal", illegal, 0);
        chk("trap_rst_state", state, S_FETCH);
`else
        do_inst(32'h0000007F, 0, 0, 0, 1'b0);
        chk("nop_illegal", illegal, 0);
        run_inst(32'h0000007F, 0, 0, 0, done, cyc, regw, pcw, drd, dwr, nonadd, xop);
        exp_ret = exp_ret + 32'd1;
        chk("nop2_retired", retired, exp_ret);
        chk("nop2_cycles", cyc, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
